// File: rtl/req_arb_pkg.sv
// Shared state type and rotate-priority first-one search for the burst-fair arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package req_arb_pkg;

  localparam int MAX_WAYS = 64;
  localparam int MAX_IW   = 6;

  typedef enum logic {IDLE, OWN} req_arb_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_WAYS-1:0] oh;
  } rr_pick_t;

  // First set bit of req starting at ptr+1, wrapping modulo ways; ptr itself is checked last.
  function automatic rr_pick_t rr_pick(input logic [MAX_WAYS-1:0] req, input int ptr, input int ways);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int i = 1; i <= MAX_WAYS; i++) begin
      idx = ptr + i;
      if (idx >= ways) idx = idx - ways;
      if (i <= ways && !res.found && req[idx[MAX_IW-1:0]]) begin
        res.found                = 1'b1;
        res.oh[idx[MAX_IW-1:0]] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/req_arb_skid.sv
// Two-entry valid/ready buffer with registered output decoupling the arbiter from the consumer.
// Latency: one cycle from push to out_vld.
// Backpressure: in_rdy depends only on occupancy (low when both entries are full), never on out_rdy.
module req_arb_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = head_q;

  always_comb begin
    push   = in_vld && in_rdy;
    pop    = out_vld && out_rdy;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_d - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) head_d = in_dat;
      else               tail_d = in_dat;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/req_arb_wrr.sv
// Burst-fair round-robin merge of WAYS request streams; optional urgent class under REQ_ARB_URGENT_EN.
// Latency: input transfer in cycle N shows o_v in cycle N+1; 1 transfer/cycle sustained.
// Backpressure: i_r is registered-state driven; no grant while the two-entry output stage is full.
module req_arb_wrr import req_arb_pkg::*; #(
  parameter int WAYS  = 16,
  parameter int WIDTH = 1,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WAYS-1:0]         i_v,
  output logic [WAYS-1:0]         i_r,
  input  logic [WAYS*WIDTH-1:0]   i_d,
`ifdef REQ_ARB_URGENT_EN
  input  logic [WAYS-1:0]         i_urg,
`endif
  output logic                    o_v,
  input  logic                    o_r,
  output logic [WIDTH-1:0]        o_d,
  output logic [$clog2(WAYS)-1:0] o_sel
);

  localparam int SW = $clog2(WAYS);
  localparam int CW = $clog2(BURST+1);

  req_arb_state_t state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WAYS-1:0] req, gnt;
  logic [SW-1:0]  gnt_sel;
  logic [WIDTH-1:0] gnt_dat;
  logic           space, hold;
  rr_pick_t       pick;

  always_comb begin
    req = i_v;
`ifdef REQ_ARB_URGENT_EN
    // Urgent requests shrink the eligible set, which also evicts a non-urgent owner.
    if (|(i_v & i_urg)) req = i_v & i_urg;
`endif
    pick    = rr_pick(MAX_WAYS'(req), int'(ptr_q), WAYS);
    hold    = (state_q == OWN) && req[ptr_q] && (cnt_q < CW'(BURST));
    gnt     = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (space && !reset) begin
      if (hold) begin
        gnt[ptr_q] = 1'b1;
        cnt_d      = cnt_q + CW'(1);
      end else if (pick.found) begin
        gnt     = WAYS'(pick.oh);
        cnt_d   = CW'(1);
        state_d = OWN;
      end else begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
    gnt_sel = '0;
    gnt_dat = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (gnt[k]) begin
        gnt_sel = gnt_sel | SW'(k);
        gnt_dat = gnt_dat | i_d[k*WIDTH +: WIDTH];
      end
    end
    if (|gnt) ptr_d = gnt_sel;
  end

  assign i_r = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= SW'(WAYS-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  req_arb_skid #(.W(WIDTH+SW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (|gnt),
    .in_rdy  (space),
    .in_dat  ({gnt_sel, gnt_dat}),
    .out_vld (o_v),
    .out_rdy (o_r),
    .out_dat ({o_sel, o_d})
  );

endmodule

// File: tb/tb_req_arb_wrr.sv
// Randomised and directed bench for req_arb_wrr against a queue-based model of the grant rules.
module tb_req_arb_wrr;
  localparam int W  = 4;
  localparam int B  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  i_v   = '0;
  logic [W-1:0]  i_r;
  logic [W*DW-1:0] i_d = '0;
  logic [W-1:0]  urg   = '0;
  logic          o_v;
  logic          o_r   = 1'b0;
  logic [DW-1:0] o_d;
  logic [SW-1:0] o_sel;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: current owner, burst count and the expected output queue (sel*256+data).
  int m_ptr = W-1;
  int m_cnt = 0;
  bit m_own = 1'b0;
  int q[$];
  int out_log[$];
  int acc_cnt = 0;

  always #5 clk = ~clk;

  req_arb_wrr #(.WAYS(W), .WIDTH(DW), .BURST(B)) dut (
    .clk   (clk),
    .reset (reset),
    .i_v   (i_v),
    .i_r   (i_r),
    .i_d   (i_d),
`ifdef REQ_ARB_URGENT_EN
    .i_urg (urg),
`endif
    .o_v   (o_v),
    .o_r   (o_r),
    .o_d   (o_d),
    .o_sel (o_sel)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input int exp);
    if (out_log.size() <= idx) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s[%0d]: got no output expected %0d", nm, idx, exp);
    end else begin
      check($sformatf("%s[%0d]", nm, idx), out_log[idx], exp);
    end
  endtask

  always @(negedge clk) begin
    int win;
    bit held;
    logic [W-1:0] elig;
    win  = -1;
    held = 1'b0;
    elig = i_v;
    if ((i_v & urg) != '0) elig = i_v & urg;
    if (!reset && q.size() < 2) begin
      if (m_own && elig[m_ptr] && m_cnt < B) begin
        win  = m_ptr;
        held = 1'b1;
      end else begin
        for (int j = 1; j <= W; j++)
          if (win < 0 && elig[(m_ptr + j) % W]) win = (m_ptr + j) % W;
      end
    end
    check("i_r", int'(i_r), (win < 0) ? 0 : (1 << win));
    check("o_v", int'(o_v), int'(q.size() != 0));
    if (q.size() != 0) begin
      check("o_sel", int'(o_sel), q[0] / 256);
      check("o_d", int'(o_d), q[0] % 256);
    end
    if (reset) begin
      q.delete();
      m_ptr = W-1;
      m_cnt = 0;
      m_own = 1'b0;
    end else begin
      if (o_v && o_r) out_log.push_back(int'(o_sel) * 256 + int'(o_d));
      if ((i_v & i_r) != '0) acc_cnt++;
      if (win >= 0) begin
        m_cnt = held ? m_cnt + 1 : 1;
        m_ptr = win;
        m_own = 1'b1;
      end else if (q.size() < 2) begin
        m_own = 1'b0;
      end
      if (q.size() != 0 && o_r) void'(q.pop_front());
      if (win >= 0) q.push_back(win * 256 + int'(i_d[win*DW +: DW]));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    i_v   = '0;
    urg   = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    out_log.delete();
    acc_cnt = 0;
  endtask

  initial begin
    i_d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    i_v = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_r", int'(i_r), 0);
    check("rst_o_v", int'(o_v), 0);

    // Full load: four-grant bursts rotating 0,1,2,3,0.
    reset = 1'b0;
    o_r   = 1'b1;
    out_log.delete();
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) chk_log("t1", i, ((i / 4) % 4) * 257 + 'hA0);

    // Single requester streams without a bubble.
    do_reset();
    i_v = 4'b0100;
    repeat (10) @(posedge clk);
    #1;
    i_v = '0;
    repeat (4) @(posedge clk);
    #1;
    check("t2_count", out_log.size(), 10);
    for (int i = 0; i < 10; i++) chk_log("t2", i, 2 * 256 + 'hA2);

    // Owner drops mid-burst: stream 3 takes over in the same cycle.
    do_reset();
    i_v = 4'b1001;
    repeat (2) @(posedge clk);
    #1;
    i_v = 4'b1000;
    repeat (8) @(posedge clk);
    #1;
    chk_log("t3", 0, 'hA0);
    chk_log("t3", 1, 'hA0);
    for (int i = 2; i < 6; i++) chk_log("t3", i, 3 * 257 + 'hA0);

    // Output stalled: only two entries accepted, nothing lost afterwards.
    do_reset();
    i_v = 4'hF;
    o_r = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_accepted", acc_cnt, 2);
    check("t4_i_r_full", int'(i_r), 0);
    o_r = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk_log("t4", i, 'hA0);
    chk_log("t4", 4, 257 + 'hA0);

    // Reset in the middle of stream 1's burst.
    do_reset();
    i_v = 4'hF;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    i_v   = 4'b1100;
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_log.delete();
    check("t5_o_v", int'(o_v), 0);
    repeat (4) @(posedge clk);
    #1;
    chk_log("t5", 0, 2 * 257 + 'hA0);

    // Random traffic with occasional reset, all checked by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) i_v = W'($urandom_range(0, 15));
      o_r   = ($urandom_range(0, 9) < 7);
      i_d   = $urandom;
      reset = ($urandom_range(0, 299) == 0);
`ifdef REQ_ARB_URGENT_EN
      if ($urandom_range(0, 7) == 0) urg = W'($urandom_range(0, 15));
`endif
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_v   = '0;
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
